// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared record type, FSM states and default sizes for the commit trace buffer
package trace_pkg;

    localparam int TRACE_XLEN   = 64;
    localparam int NCOMMIT_DEF  = 2;
    localparam int DEPTH_DEF    = 8;
    localparam int TIMEOUT_DEF  = 4096;

    // Stored at the widest supported XLEN; narrower cores zero-extend on entry.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic                  wen;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] wdata;
    } commit_rec_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - multi-push, single-pop record FIFO with compacting lane writes
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  NCOMMIT = NCOMMIT_DEF,
    parameter type rec_t   = commit_rec_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCOMMIT-1:0]       push_valid,
    input  rec_t                     push_data [NCOMMIT],
    input  logic                     pop,
    output rec_t                     head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] waddr [NCOMMIT];
    logic [CNT_W-1:0] npush;
    logic             do_pop;

    // Valid lanes land in consecutive slots, lane 0 first, gaps squeezed out.
    always_comb begin
        npush = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            waddr[i] = wr_ptr + npush[PTR_W-1:0];
            npush    = npush + CNT_W'(push_valid[i]);
        end
    end

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOMMIT; i++) begin
            if (push_valid[i]) begin
                mem[waddr[i]] <= push_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + npush[PTR_W-1:0];
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + npush - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retire trace capture with ebreak/watchdog halt control and counters
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NCOMMIT = NCOMMIT_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCOMMIT-1:0]      cmt_valid,
    input  logic [NCOMMIT*XLEN-1:0] cmt_pc,
    input  logic [NCOMMIT*32-1:0]   cmt_inst,
    input  logic [NCOMMIT-1:0]      cmt_wen,
    input  logic [NCOMMIT*5-1:0]    cmt_rd,
    input  logic [NCOMMIT*XLEN-1:0] cmt_wdata,
    input  logic [NCOMMIT-1:0]      cmt_ebreak,
    input  logic [XLEN-1:0]         gpr_a0,
    output logic                    stall_req,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic                    out_wen,
    output logic [4:0]              out_rd,
    output logic [XLEN-1:0]         out_wdata,
    output logic                    halt,
    output logic                    timeout,
    output logic                    overflow,
    output logic [XLEN-1:0]         halt_code,
    output logic [63:0]             cycle_cnt,
    output logic [63:0]             instret
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    trace_state_e      state, state_next;
    logic [CNT_W-1:0]  count;
    logic [WD_W-1:0]   wd_cnt;
    commit_rec_t       push_data [NCOMMIT];
    commit_rec_t       head;
    logic [NCOMMIT-1:0] acc_mask;
    logic [2:0]        n_acc;
    logic              ebreak_hit;
    logic              commit_any;
    logic              overflow_set;
    logic              wd_expire;

    always_comb begin
        for (int i = 0; i < NCOMMIT; i++) begin
            push_data[i].pc    = TRACE_XLEN'(cmt_pc[i*XLEN +: XLEN]);
            push_data[i].inst  = cmt_inst[i*32 +: 32];
            push_data[i].wen   = cmt_wen[i];
            push_data[i].rd    = cmt_rd[i*5 +: 5];
            push_data[i].wdata = TRACE_XLEN'(cmt_wdata[i*XLEN +: XLEN]);
        end
    end

    assign stall_req = (CNT_W'(DEPTH) - count) < CNT_W'(NCOMMIT);

    // Lanes are taken in order up to and including the first ebreak; a stalled cycle takes nothing.
    always_comb begin
        acc_mask   = '0;
        n_acc      = '0;
        ebreak_hit = 1'b0;
        if (state == RUN && !stall_req) begin
            for (int i = 0; i < NCOMMIT; i++) begin
                if (cmt_valid[i] && !ebreak_hit) begin
                    acc_mask[i] = 1'b1;
                    n_acc       = n_acc + 3'd1;
                    if (cmt_ebreak[i]) begin
                        ebreak_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign commit_any   = |acc_mask;
    assign overflow_set = (state == RUN) && stall_req && (|cmt_valid);
    assign wd_expire    = (state == RUN) && !commit_any && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (ebreak_hit || wd_expire) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // rst_n deassertion is expected already aligned to clk by the reset tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wd_cnt    <= '0;
            cycle_cnt <= '0;
            instret   <= '0;
            halt_code <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_next;
            instret <= instret + 64'(n_acc);
            if (state != HALTED) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
            if (state == RUN) begin
                wd_cnt <= commit_any ? '0 : wd_cnt + WD_W'(1);
            end
            if (ebreak_hit) begin
                halt_code <= gpr_a0;
            end else if (wd_expire) begin
                halt_code <= '1;
                timeout   <= 1'b1;
            end
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .NCOMMIT (NCOMMIT),
        .rec_t   (commit_rec_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (acc_mask),
        .push_data  (push_data),
        .pop        (out_valid && out_ready),
        .head       (head),
        .count      (count)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head.pc[XLEN-1:0];
    assign out_inst  = head.inst;
    assign out_wen   = head.wen;
    assign out_rd    = head.rd;
    assign out_wdata = head.wdata[XLEN-1:0];
    assign halt      = (state == HALTED);

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath/register width.
REQ-002 SHALL have parameter NCOMMIT, default 2: commit channels per cycle, range 1..4.
REQ-003 SHALL have parameter DEPTH, default 8: record FIFO entries, power of two, at least 2*NCOMMIT.
REQ-004 SHALL have parameter TIMEOUT, default 4096: watchdog limit in cycles without a commit.
REQ-005 SHALL have ports: clk, in, 1: single clock; all state on posedge clk.
REQ-006 SHALL have ports: rst_n, in, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have ports: cmt_valid, in, NCOMMIT: per-lane retire strobe.
REQ-008 SHALL have ports: cmt_pc, in, NCOMMIT*XLEN; cmt_inst, in, NCOMMIT*32; cmt_wen, in, NCOMMIT; cmt_rd, in, NCOMMIT*5; cmt_wdata, in, NCOMMIT*XLEN; cmt_ebreak, in, NCOMMIT. Lane i occupies slice i.
REQ-009 SHALL have ports: gpr_a0, in, XLEN: current architectural a0, used as exit code.
REQ-010 SHALL have ports: stall_req, out, 1: fewer than NCOMMIT free entries.
REQ-011 SHALL have ports: out_valid, out, 1; out_ready, in, 1; out_pc, out_inst, out_wen, out_rd, out_wdata, out, widths as one lane: FIFO head record.
REQ-012 SHALL have ports: halt, out, 1; timeout, out, 1; overflow, out, 1; halt_code, out, XLEN.
REQ-013 SHALL have ports: cycle_cnt, out, 64; instret, out, 64.

Function
REQ-014 Valid lanes SHALL be enqueued in ascending lane order in the same cycle, with lane 0 oldest.
REQ-015 stall_req SHALL be combinational from the registered count: (DEPTH - count) < NCOMMIT.
REQ-016 If cmt_valid is nonzero while stall_req=1, the block SHALL drop all lanes that cycle and set the sticky overflow flag, with no partial enqueue.
REQ-017 out_valid SHALL equal FIFO non-empty, and out_* SHALL present the head record.
REQ-018 The head SHALL pop on out_valid&out_ready, with a 1-cycle enqueue-to-out_valid latency.
REQ-019 Simultaneous push and pop SHALL be legal, with count updated by the net change.
REQ-020 Pointers SHALL wrap modulo DEPTH.
REQ-021 The FSM SHALL have states RUN, DRAIN and HALTED, and SHALL reset to RUN.
REQ-022 In RUN, the lowest lane with cmt_valid&cmt_ebreak SHALL be enqueued as normal; higher lanes that cycle SHALL be discarded.
REQ-023 On that ebreak, halt_code SHALL latch gpr_a0 and the FSM SHALL go to DRAIN.
REQ-024 In DRAIN and HALTED, cmt_* SHALL be ignored: no enqueue, no overflow, no instret change.
REQ-025 DRAIN SHALL go to HALTED in the cycle after count reaches 0.
REQ-026 halt SHALL be 1 only in HALTED; HALTED SHALL be terminal until reset.
REQ-027 The watchdog counter SHALL clear on any accepted commit and increment otherwise, only in RUN.
REQ-028 When the watchdog reaches TIMEOUT, the FSM SHALL go to DRAIN, set timeout=1 and set halt_code = all-ones.
REQ-029 An ebreak in the same cycle as a watchdog expiry SHALL take priority: timeout=0 and halt_code=a0.
REQ-030 cycle_cnt SHALL increment every cycle outside HALTED.
REQ-031 instret SHALL add the popcount of accepted lanes, including the ebreak lane.
REQ-032 Both 64-bit counters SHALL wrap.

Reset
REQ-033 On rst_n=0, the block SHALL asynchronously clear pointers, count, FSM (to RUN), watchdog, cycle_cnt, instret, halt_code, overflow and timeout.
REQ-034 On rst_n=0, outputs SHALL be: out_valid=0, stall_req=0, halt=0.
REQ-035 Reset mid-DRAIN SHALL discard FIFO contents.
REQ-036 Reset deassertion SHALL be used synchronised, and the first commit SHALL be accepted in the first cycle after release.

Structure
REQ-037 Package trace_pkg SHALL hold the commit_rec_t struct (pc, inst, wen, rd, wdata), the trace_state_e enum and the default parameter constants.
REQ-038 The FIFO SHALL be the sub-module trace_fifo, which has multi-push/single-pop and is parametrised by DEPTH, NCOMMIT and the record type.
REQ-039 The FSM, watchdog and counters SHALL reside in the top module.

Verification
REQ-040 Reset scenario: assert rst_n=0 mid-traffic -> all outputs zero, and out_valid=0 next cycle.
REQ-041 Dual-lane scenario: NCOMMIT=2, with cmt_valid=2'b11 on pc 0x80000000/0x80000004 and out_ready=1 -> out pops 0x80000000 then 0x80000004, and instret=2.
REQ-042 Stall/overflow scenario: out_ready=0, fill to DEPTH-1 -> stall_req=1; drive cmt_valid=2'b01 -> no enqueue, overflow=1, count unchanged.
REQ-043 Ebreak scenario: lane0 ebreak with gpr_a0=0 and lane1 valid -> lane1 discarded; after the FIFO drains, halt=1 one cycle later with halt_code=0.
REQ-044 Timeout scenario: TIMEOUT=16 with no commits -> timeout=1 and halt_code=all-ones; halt=1 at cycle 17 or 18.
REQ-045 Wrap scenario: DEPTH=8, stream 20 records with random out_ready -> output order and data match input, with no loss.
